// File: rtl/idma_eh_policy_ctrl_pkg.sv
// Shared types for the iDMA error-handling policy controller.
package idma_eh_policy_ctrl_pkg;

  localparam int unsigned PldWidth = 8;

  // Error-handling policy selected by software
  typedef enum logic [1:0] {
    FORWARD         = 2'd0,
    AUTO_CONTINUE   = 2'd1,
    AUTO_ABORT      = 2'd2,
    FORWARD_TIMEOUT = 2'd3
  } eh_policy_e;

  // Error-handling decision sent to the backend
  typedef enum logic {
    CONTINUE = 1'b0,
    ABORT    = 1'b1
  } eh_req_e;

  // 1D backend response
  typedef struct packed {
    logic                error;
    logic                last;
    logic [PldWidth-1:0] pld;
  } rsp_t;

  // Controller FSM states
  typedef enum logic [1:0] {
    IDLE,
    WAIT_SW,
    ISSUE_EH
  } eh_state_e;

endpackage

// File: rtl/idma_eh_policy_ctrl_counter.sv
// Up-counter with synchronous clear (clear has priority over enable).
module idma_eh_policy_ctrl_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] cnt_q;

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/idma_eh_policy_ctrl.sv
// Error-policy controller: forwards 1D responses to the frontend and, on an
// error, produces a CONTINUE/ABORT decision for the backend from the
// configured policy (auto, software, or software with timeout abort).
module idma_eh_policy_ctrl
  import idma_eh_policy_ctrl_pkg::*;
#(
  parameter int unsigned TimeoutWidth  = 16,
  parameter int unsigned CntWidth      = 8,
  parameter type         idma_rsp_t    = rsp_t,
  parameter type         idma_eh_req_t = eh_req_e
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              cfg_policy_i,
  input  logic [TimeoutWidth-1:0] cfg_timeout_i,
  input  idma_rsp_t               be_rsp_i,
  input  logic                    be_rsp_valid_i,
  output logic                    be_rsp_ready_o,
  output idma_rsp_t               fe_rsp_o,
  output logic                    fe_rsp_valid_o,
  input  logic                    fe_rsp_ready_i,
  input  idma_eh_req_t            sw_eh_i,
  input  logic                    sw_eh_valid_i,
  output logic                    sw_eh_ready_o,
  output idma_eh_req_t            eh_o,
  output logic                    eh_valid_o,
  input  logic                    eh_ready_i,
  output logic [CntWidth-1:0]     err_cnt_o,
  input  logic                    err_cnt_clr_i,
  output logic                    timeout_o,
  output logic                    busy_o
);

  eh_state_e                 state_q, state_d;
  eh_policy_e                pol_q;
  eh_policy_e                cfg_pol;
  logic [TimeoutWidth-1:0]   tmo_q;
  logic [TimeoutWidth-1:0]   tcnt;
  idma_eh_req_t              eh_q;
  logic                      eh_valid_q;
  logic                      timeout_q;
  logic [CntWidth-1:0]       err_cnt_q;
  logic                      err_hs;
  logic                      sw_hs;
  logic                      tmo_hit;
  logic                      auto_pol;

  assign cfg_pol  = eh_policy_e'(cfg_policy_i);
  assign auto_pol = (cfg_pol == AUTO_CONTINUE) || (cfg_pol == AUTO_ABORT);
  assign err_hs   = (state_q == IDLE) && be_rsp_valid_i && fe_rsp_ready_i && be_rsp_i.error;
  assign sw_hs    = (state_q == WAIT_SW) && sw_eh_valid_i;
  // Software wins a same-cycle race with the timeout
  assign tmo_hit  = (state_q == WAIT_SW) && (pol_q == FORWARD_TIMEOUT) &&
                    (tcnt == tmo_q) && !sw_eh_valid_i;

  idma_eh_policy_ctrl_counter #(
    .Width (TimeoutWidth)
  ) i_timeout_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (err_hs && !auto_pol),
    .en_i    (state_q == WAIT_SW),
    .q_o     (tcnt)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (err_hs) state_d = auto_pol ? ISSUE_EH : WAIT_SW;
      WAIT_SW:  if (sw_hs || tmo_hit) state_d = ISSUE_EH;
      ISSUE_EH: if (eh_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake gating and pass-through outputs
  always_comb begin
    fe_rsp_o       = be_rsp_i;
    fe_rsp_valid_o = (state_q == IDLE) && be_rsp_valid_i;
    be_rsp_ready_o = (state_q == IDLE) && fe_rsp_ready_i;
    sw_eh_ready_o  = (state_q == WAIT_SW);
    busy_o         = (state_q != IDLE);
  end

  // Latched configuration, decision and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pol_q      <= FORWARD;
      tmo_q      <= '0;
      eh_q       <= idma_eh_req_t'(CONTINUE);
      eh_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      eh_valid_q <= (state_d == ISSUE_EH);
      timeout_q  <= tmo_hit;
      if (err_hs) begin
        pol_q <= cfg_pol;
        tmo_q <= cfg_timeout_i;
        if (cfg_pol == AUTO_CONTINUE) eh_q <= idma_eh_req_t'(CONTINUE);
        if (cfg_pol == AUTO_ABORT)    eh_q <= idma_eh_req_t'(ABORT);
      end else if (sw_hs) begin
        eh_q <= sw_eh_i;
      end else if (tmo_hit) begin
        eh_q <= idma_eh_req_t'(ABORT);
      end
    end
  end

  // Saturating error counter; an error coinciding with a clear counts as one
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (err_hs) begin
      if (err_cnt_clr_i)   err_cnt_q <= CntWidth'(1);
      else if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + CntWidth'(1);
    end else if (err_cnt_clr_i) begin
      err_cnt_q <= '0;
    end
  end

  assign eh_o       = eh_q;
  assign eh_valid_o = eh_valid_q;
  assign timeout_o  = timeout_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_idma_eh_policy_ctrl.sv
// Self-checking bench for idma_eh_policy_ctrl: directed vector table,
// hand sequences for reset/counter corners, and randomized errors checked
// against a latency/decision model derived from the policy rules.
module tb_idma_eh_policy_ctrl;
  import idma_eh_policy_ctrl_pkg::*;

  localparam int unsigned TW = 16;
  localparam int unsigned CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [1:0]    cfg_policy_i;
  logic [TW-1:0] cfg_timeout_i;
  rsp_t          be_rsp_i;
  logic          be_rsp_valid_i;
  logic          be_rsp_ready_o;
  rsp_t          fe_rsp_o;
  logic          fe_rsp_valid_o;
  logic          fe_rsp_ready_i;
  eh_req_e       sw_eh_i;
  logic          sw_eh_valid_i;
  logic          sw_eh_ready_o;
  eh_req_e       eh_o;
  logic          eh_valid_o;
  logic          eh_ready_i;
  logic [CW-1:0] err_cnt_o;
  logic          err_cnt_clr_i;
  logic          timeout_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  idma_eh_policy_ctrl #(
    .TimeoutWidth (TW),
    .CntWidth     (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cfg_policy_i   (cfg_policy_i),
    .cfg_timeout_i  (cfg_timeout_i),
    .be_rsp_i       (be_rsp_i),
    .be_rsp_valid_i (be_rsp_valid_i),
    .be_rsp_ready_o (be_rsp_ready_o),
    .fe_rsp_o       (fe_rsp_o),
    .fe_rsp_valid_o (fe_rsp_valid_o),
    .fe_rsp_ready_i (fe_rsp_ready_i),
    .sw_eh_i        (sw_eh_i),
    .sw_eh_valid_i  (sw_eh_valid_i),
    .sw_eh_ready_o  (sw_eh_ready_o),
    .eh_o           (eh_o),
    .eh_valid_o     (eh_valid_o),
    .eh_ready_i     (eh_ready_i),
    .err_cnt_o      (err_cnt_o),
    .err_cnt_clr_i  (err_cnt_clr_i),
    .timeout_o      (timeout_o),
    .busy_o         (busy_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int model_cnt = 0;

  typedef struct {
    int   pol;
    int   t;
    int   k;       // WAIT_SW cycle in which software presents (0: already before, -1: never)
    logic swd;
    int   rd;      // cycles eh_ready_i is held low
    logic clr;
    logic exp_dec;
    int   exp_lat; // cycles from error handshake to eh_valid_o
    logic exp_tmo;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: decision, latency and timeout pulse from the policy rules
  function automatic void predict(input int pol, input int t, input int k, input logic swd,
                                  output logic dec, output int lat, output logic tmo);
    int ks;
    ks = (k < 0) ? 1000000 : ((k < 1) ? 1 : k);
    tmo = 1'b0;
    case (pol)
      1: begin dec = 1'b0; lat = 1; end
      2: begin dec = 1'b1; lat = 1; end
      0: begin dec = swd;  lat = ks + 1; end
      default: begin
        if (ks <= t + 1) begin dec = swd; lat = ks + 1; end
        else begin dec = 1'b1; lat = t + 2; tmo = 1'b1; end
      end
    endcase
  endfunction

  // OK responses pass straight through, in order, with ready toggled
  task automatic pass_ok(input int n, input bit rnd);
    rsp_t q[$];
    rsp_t r;
    int   guard = 0;
    for (int i = 0; i < n; i++) begin
      r.error = 1'b0;
      r.last  = 1'($urandom);
      r.pld   = PldWidth'($urandom);
      q.push_back(r);
    end
    while (q.size() > 0 && guard < 100) begin
      guard++;
      be_rsp_i       = q[0];
      be_rsp_valid_i = 1'b1;
      fe_rsp_ready_i = rnd ? 1'($urandom) : 1'(guard % 2);
      @(negedge clk_i);
      check("pt_valid", 64'(fe_rsp_valid_o), 64'(1));
      check("pt_data", 64'(fe_rsp_o), 64'(q[0]));
      check("pt_ready", 64'(be_rsp_ready_o), 64'(fe_rsp_ready_i));
      check("pt_no_eh", 64'(eh_valid_o), 64'(0));
      @(posedge clk_i); #1;
      if (fe_rsp_ready_i) void'(q.pop_front());
    end
    be_rsp_valid_i = 1'b0;
    fe_rsp_ready_i = 1'b0;
    check("pt_drained", 64'(q.size()), 64'(0));
  endtask

  // One error response with an OK response queued behind it
  task automatic run_err(input int pol, input int t, input int k, input logic swd,
                         input int rd, input logic clr, input logic exp_dec,
                         input int exp_lat, input logic exp_tmo, input int exp_cnt);
    rsp_t er, ok;
    int   c;
    bit   seen, acc;
    er.error = 1'b1; er.last = 1'b1; er.pld = PldWidth'($urandom);
    ok.error = 1'b0; ok.last = 1'b0; ok.pld = PldWidth'($urandom);
    cfg_policy_i   = 2'(pol);
    cfg_timeout_i  = TW'(t);
    be_rsp_i       = er;
    be_rsp_valid_i = 1'b1;
    fe_rsp_ready_i = 1'b1;
    err_cnt_clr_i  = clr;
    sw_eh_i        = eh_req_e'(swd);
    sw_eh_valid_i  = (k == 0);
    @(negedge clk_i);
    check("err_fwd_valid", 64'(fe_rsp_valid_o), 64'(1));
    check("err_fwd_data", 64'(fe_rsp_o), 64'(er));
    check("idle_sw_ready", 64'(sw_eh_ready_o), 64'(0));
    @(posedge clk_i); #1;
    err_cnt_clr_i = 1'b0;
    c = 0; seen = 0; acc = 0;
    while (!seen && c < 300) begin
      c++;
      cfg_policy_i   = 2'($urandom);
      cfg_timeout_i  = TW'($urandom_range(0, 3));
      be_rsp_i       = ok;
      be_rsp_valid_i = 1'b1;
      fe_rsp_ready_i = 1'b1;
      sw_eh_valid_i  = (k >= 0 && c >= k && !acc);
      @(negedge clk_i);
      if (sw_eh_valid_i && sw_eh_ready_o) acc = 1;
      check("stall_ready", 64'(be_rsp_ready_o), 64'(0));
      check("stall_valid", 64'(fe_rsp_valid_o), 64'(0));
      check("busy", 64'(busy_o), 64'(1));
      if (eh_valid_o) begin
        seen = 1;
        check("eh_latency", 64'(c), 64'(exp_lat));
        check("eh_dec", 64'(eh_o), 64'(exp_dec));
        check("timeout_pulse", 64'(timeout_o), 64'(exp_tmo));
      end else begin
        check("no_early_timeout", 64'(timeout_o), 64'(0));
      end
      @(posedge clk_i); #1;
    end
    if (!seen) check("eh_valid_bound", 64'(seen), 64'(1));
    sw_eh_valid_i = 1'b0;
    for (int r = 0; r < rd; r++) begin
      @(negedge clk_i);
      check("eh_hold_valid", 64'(eh_valid_o), 64'(1));
      check("eh_hold_dec", 64'(eh_o), 64'(exp_dec));
      check("timeout_one_cycle", 64'(timeout_o), 64'(0));
      check("hold_stall", 64'(fe_rsp_valid_o), 64'(0));
      @(posedge clk_i); #1;
    end
    eh_ready_i = 1'b1;
    @(negedge clk_i);
    check("eh_valid_at_ready", 64'(eh_valid_o), 64'(1));
    @(posedge clk_i); #1;
    eh_ready_i = 1'b0;
    @(negedge clk_i);
    check("idle_busy", 64'(busy_o), 64'(0));
    check("idle_eh_valid", 64'(eh_valid_o), 64'(0));
    check("queued_valid", 64'(fe_rsp_valid_o), 64'(1));
    check("queued_data", 64'(fe_rsp_o), 64'(ok));
    check("queued_ready", 64'(be_rsp_ready_o), 64'(1));
    check("err_cnt", 64'(err_cnt_o), 64'(exp_cnt));
    @(posedge clk_i); #1;
    be_rsp_valid_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   pol, t, k, rd;
    logic swd, clr, dec, tmo;
    int   lat;
    rsp_t er;

    // pol  t   k  swd rd clr dec lat tmo cnt
    vecs.push_back('{2, 0, -1, 1'b0, 2, 1'b0, 1'b1,  1, 1'b0, 1});
    vecs.push_back('{1, 0, -1, 1'b1, 0, 1'b0, 1'b0,  1, 1'b0, 2});
    vecs.push_back('{0, 0, 50, 1'b0, 1, 1'b0, 1'b0, 51, 1'b0, 3});
    vecs.push_back('{3, 5, -1, 1'b0, 0, 1'b0, 1'b1,  7, 1'b1, 3});
    vecs.push_back('{3, 5,  6, 1'b0, 1, 1'b0, 1'b0,  7, 1'b0, 3});
    vecs.push_back('{3, 0, -1, 1'b0, 0, 1'b1, 1'b1,  2, 1'b1, 1});
    vecs.push_back('{3, 3,  2, 1'b1, 2, 1'b0, 1'b1,  3, 1'b0, 2});
    vecs.push_back('{0, 0,  0, 1'b1, 0, 1'b0, 1'b1,  2, 1'b0, 3});
    vecs.push_back('{1, 2, -1, 1'b1, 1, 1'b0, 1'b0,  1, 1'b0, 3});

    rst_ni = 1'b0;
    cfg_policy_i = '0; cfg_timeout_i = '0;
    be_rsp_i = '0; be_rsp_valid_i = 1'b0; fe_rsp_ready_i = 1'b0;
    sw_eh_i = CONTINUE; sw_eh_valid_i = 1'b0;
    eh_ready_i = 1'b0; err_cnt_clr_i = 1'b0;
    #12;
    check("rst_eh_valid", 64'(eh_valid_o), 64'(0));
    check("rst_eh", 64'(eh_o), 64'(CONTINUE));
    check("rst_timeout", 64'(timeout_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_err_cnt", 64'(err_cnt_o), 64'(0));
    check("rst_sw_ready", 64'(sw_eh_ready_o), 64'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    pass_ok(3, 0);
    check("pt_err_cnt", 64'(err_cnt_o), 64'(0));

    foreach (vecs[i]) begin
      run_err(vecs[i].pol, vecs[i].t, vecs[i].k, vecs[i].swd, vecs[i].rd, vecs[i].clr,
              vecs[i].exp_dec, vecs[i].exp_lat, vecs[i].exp_tmo, vecs[i].exp_cnt);
    end
    model_cnt = 3;

    // Clear on its own empties the counter
    err_cnt_clr_i = 1'b1;
    @(posedge clk_i); #1;
    err_cnt_clr_i = 1'b0;
    @(negedge clk_i);
    check("clr_alone", 64'(err_cnt_o), 64'(0));
    @(posedge clk_i); #1;

    // Reset while a decision is pending
    er.error = 1'b1; er.last = 1'b0; er.pld = 8'h5a;
    cfg_policy_i = 2'd2; be_rsp_i = er; be_rsp_valid_i = 1'b1; fe_rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    be_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    check("pre_rst_eh_valid", 64'(eh_valid_o), 64'(1));
    check("pre_rst_busy", 64'(busy_o), 64'(1));
    check("pre_rst_cnt", 64'(err_cnt_o), 64'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_eh_valid", 64'(eh_valid_o), 64'(0));
    check("mid_rst_eh", 64'(eh_o), 64'(CONTINUE));
    check("mid_rst_busy", 64'(busy_o), 64'(0));
    check("mid_rst_timeout", 64'(timeout_o), 64'(0));
    check("mid_rst_cnt", 64'(err_cnt_o), 64'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    run_err(vecs[0].pol, vecs[0].t, vecs[0].k, vecs[0].swd, vecs[0].rd, vecs[0].clr,
            vecs[0].exp_dec, vecs[0].exp_lat, vecs[0].exp_tmo, 1);
    model_cnt = 1;

    // Randomized errors against the reference model
    for (int i = 0; i < 40; i++) begin
      pol = $urandom_range(0, 3);
      t   = $urandom_range(0, 8);
      if (pol == 1 || pol == 2) k = -1;
      else if (pol == 0) k = $urandom_range(0, 14);
      else k = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 14);
      swd = 1'($urandom);
      rd  = $urandom_range(0, 3);
      clr = ($urandom_range(0, 7) == 0);
      predict(pol, t, k, swd, dec, lat, tmo);
      model_cnt = clr ? 1 : ((model_cnt < 3) ? model_cnt + 1 : 3);
      run_err(pol, t, k, swd, rd, clr, dec, lat, tmo, model_cnt);
      if ($urandom_range(0, 2) == 0) pass_ok($urandom_range(1, 3), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
